// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-to-host receiver:
// FSM state encoding, frame geometry and the odd-parity check.
package ps2_pkg;

    localparam int PS2_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    // True when data byte plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] b,
                                           input logic                     p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the raw PS/2 pins, falling-edge detector on the
// clock pin and the data bit captured alongside each edge.
// Optional clock-pin glitch filter enabled by defining PS2_GLITCH_FILTER_EN.
module ps2_sync_edge #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_bit
);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_lvl;
    logic       clk_prev;

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    // Synchronise both pins; preset high so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] filt_cnt;
    logic          filt_q;

    // Follow the synced clock only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] == filt_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == CW'(FILTER_LEN - 1)) begin
            filt_q   <= clk_sync[1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + CW'(1);
        end
    end

    assign clk_lvl = filt_q;
`else
    assign clk_lvl = clk_sync[1];
`endif

    // Register the falling-edge strobe together with the data bit of that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev <= 1'b1;
            fall     <= 1'b0;
            data_bit <= 1'b1;
        end else begin
            clk_prev <= clk_lvl;
            fall     <= clk_prev & ~clk_lvl;
            data_bit <= data_sync[1];
        end
    end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames (start, 8 data
// LSB first, odd parity, stop) and strobes each good byte to mouseDecoder.
// Bad frames raise parityErr or frameErr; a watchdog aborts stalled frames.
// Optional clock glitch filter: define PS2_GLITCH_FILTER_EN.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] mouseData,
    output logic       mouseReady,
    output logic       parityErr,
    output logic       frameErr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic fall;
    logic data_bit;

    ps2_state_t               state, state_n;
    logic [2:0]               bitcnt, bitcnt_n;
    logic [PS2_DATA_BITS-1:0] shreg, shreg_n;
    logic                     par, par_n;
    logic [TW-1:0]            timer, timer_n;
    logic [7:0]               data_n;
    logic                     ready_n, perr_n, ferr_n;

    ps2_sync_edge #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .fall    (fall),
        .data_bit(data_bit)
    );

    // Frame state, watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            timer      <= '0;
            mouseData  <= '0;
            mouseReady <= 1'b0;
            parityErr  <= 1'b0;
            frameErr   <= 1'b0;
        end else begin
            state      <= state_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            timer      <= timer_n;
            mouseData  <= data_n;
            mouseReady <= ready_n;
            parityErr  <= perr_n;
            frameErr   <= ferr_n;
        end
    end

    // Next-state: advance on falling edges, evaluate the frame at STOP, abort on timeout.
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par;
        timer_n  = (state == IDLE) ? '0 : timer + TW'(1);
        data_n   = mouseData;
        ready_n  = 1'b0;
        perr_n   = 1'b0;
        ferr_n   = 1'b0;

        if (fall) begin
            timer_n = '0;
            unique case (state)
                IDLE: begin
                    if (!data_bit) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n  = {data_bit, shreg[PS2_DATA_BITS-1:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'(PS2_DATA_BITS - 1))
                        state_n = PARITY;
                end
                PARITY: begin
                    par_n   = data_bit;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!data_bit) begin
                        ferr_n = 1'b1;
                    end else if (odd_parity_ok(shreg, par)) begin
                        data_n  = shreg;
                        ready_n = 1'b1;
                    end else begin
                        perr_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            timer_n = '0;
            ferr_n  = 1'b1;
        end
    end

endmodule

// File: doc/ps2_mouse_rx.md
Name: ps2_mouse_rx

Overview:
PS/2 device-to-host receiver sitting directly upstream of mouseDecoder. Synchronises the raw ps2_clk/ps2_data pins, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop) and presents each good byte as mouseData with a one-cycle mouseReady strobe. Bad frames are dropped and flagged; a stalled frame is aborted by a watchdog.

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles allowed between ps2_clk falling edges inside a frame before abort (1 ms at 100 MHz)
FILTER_LEN, 4, consecutive equal samples required by the optional glitch filter

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous to clk, active-high
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
mouseData  out  8  last correctly received byte
mouseReady  out  1  one-cycle strobe, mouseData valid and new
parityErr  out  1  one-cycle strobe, frame dropped on parity
frameErr  out  1  one-cycle strobe, frame dropped on bad start/stop or timeout

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; mouseData=0; mouseReady=parityErr=frameErr=0; bit counter, shift register, timer cleared; synchroniser flops preset to 1 (idle bus high) so release of reset never produces a false edge.
- Sync: ps2_clk and ps2_data each pass two flops. Falling edge = previous synced clk 1, current synced clk 0. Data bit taken from synced ps2_data in the same cycle the edge is detected.
- FSM, advancing only on a detected falling edge:
  IDLE: data 0 -> DATA, bitcnt=0, timer=0. Data 1 -> stay IDLE, no flag.
  DATA: shift bit into MSB (shift right), bitcnt+1; after 8th bit -> PARITY.
  PARITY: store bit -> STOP.
  STOP: evaluate, return to IDLE.
- STOP evaluation (same cycle as stop edge, outputs registered, visible next cycle):
  stop=1 and XOR(byte,parity)=1 -> mouseData<=byte, mouseReady=1 for exactly one cycle.
  stop=0 -> frameErr pulse only (precedence over parity).
  stop=1, parity wrong -> parityErr pulse only.
  At most one of the three strobes high in any cycle.
- Latency: mouseReady high 4 clk cycles after the raw ps2_clk falling edge of the stop bit (2 sync + 1 detect + 1 output register), without filter.
- mouseData holds the last good byte; errors never modify it.
- Watchdog: in any non-IDLE state, timer increments each cycle and clears on every falling edge; when timer reaches TIMEOUT_CYCLES-1 -> IDLE, frameErr pulse, partial byte discarded. Timer is not running in IDLE.
- rst mid-frame: frame abandoned, no strobe issued, next frame decoded normally.
- Back-to-back frames with no idle gap are accepted; the next start bit may arrive on the falling edge right after STOP.

Optional Feature:
PS2_GLITCH_FILTER_EN
- Defined: synced ps2_clk feeds a filter whose output changes only after FILTER_LEN consecutive equal samples; edge detect uses the filtered level; latency grows by FILTER_LEN cycles. Pulses shorter than FILTER_LEN cycles are ignored.
- Undefined: edge detect uses the 2-flop synced level directly; no filter logic.

Decomposition:
- Package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), PS2_DATA_BITS=8, odd-parity check function.
- One sub-module: ps2_sync_edge (2-flop sync of both pins, optional filter, falling-edge strobe output plus synced data bit).

Test Plan:
(Sim: TIMEOUT_CYCLES=200, ps2_clk half-period 20 clk cycles)
- Frame 0x21 parity 1 stop 1 -> mouseData=0x21, mouseReady exactly one cycle, 4 cycles after stop edge; no error strobes.
- Frames 0x08, 0x05, 0x0A back-to-back -> three mouseReady pulses, mouseData 0x08, 0x05, 0x0A in order.
- Frame 0xF0 with parity 0 (wrong) -> parityErr one cycle, no mouseReady, mouseData stays 0x0A.
- Frame 0x01 with stop bit 0 -> frameErr one cycle, no mouseReady; wrong parity too still gives frameErr only.
- 5 bits then ps2_clk held high -> frameErr at 200 cycles after last edge, state IDLE; following 0x08 frame decoded correctly.
- rst pulsed after 4 bits of a frame -> no strobes, outputs zero; next 0x21 frame decoded; with PS2_GLITCH_FILTER_EN, 2-cycle ps2_clk low glitches inserted -> same result.
